// File: rtl/ram_word_packer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_word_packer_if : host-side bus of the narrow-to-wide RAM pack engine  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface ram_word_packer_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 2,
  parameter int IN_DEPTH = 32
);
  localparam int OUT_DEPTH = IN_DEPTH / RATIO;
  localparam int IN_AW     = $clog2(IN_DEPTH);
  localparam int OUT_AW    = $clog2(OUT_DEPTH);

  logic                      in_we;
  logic [IN_AW-1:0]          in_addr_wr;
  logic [IN_WIDTH-1:0]       in_data_wr;
  logic [OUT_AW-1:0]         out_addr_rd;
  logic [IN_WIDTH*RATIO-1:0] out_data_rd;
  logic                      start;
  logic                      abort;
  logic                      msb_first;
  logic [OUT_AW-1:0]         len_in;
  logic                      busy;
  logic                      done;
  logic [OUT_AW:0]           words_done;

  modport slave (
    input  in_we, in_addr_wr, in_data_wr, out_addr_rd, start, abort, msb_first, len_in,
    output out_data_rd, busy, done, words_done
  );

  modport master (
    output in_we, in_addr_wr, in_data_wr, out_addr_rd, start, abort, msb_first, len_in,
    input  out_data_rd, busy, done, words_done
  );
endinterface
`default_nettype wire

// File: rtl/ram_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_word_packer : packs RATIO narrow input-RAM words into one output word |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module ram_word_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 2,
  parameter int IN_DEPTH = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  ram_word_packer_if.slave bus
);
  localparam int OUT_DEPTH = IN_DEPTH / RATIO;
  localparam int IN_AW     = $clog2(IN_DEPTH);
  localparam int OUT_AW    = $clog2(OUT_DEPTH);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int LANE_W    = $clog2(RATIO);

  localparam logic [LANE_W-1:0] c_LANE_LAST = LANE_W'(RATIO - 1);
  localparam logic [LANE_W-1:0] c_LANE_ONE  = LANE_W'(1);
  localparam logic [IN_AW-1:0]  c_IN_ONE    = IN_AW'(1);
  localparam logic [OUT_AW-1:0] c_OUT_ONE   = OUT_AW'(1);
  localparam logic [OUT_AW:0]   c_WD_ONE    = (OUT_AW + 1)'(1);
  localparam logic [OUT_AW:0]   c_OUT_DEPTH = (OUT_AW + 1)'(OUT_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IN_WIDTH-1:0]   r_in_ram  [IN_DEPTH];
  logic [OUT_WIDTH-1:0]  r_out_ram [OUT_DEPTH];
  logic [OUT_WIDTH-1:0]  r_pack;
  logic [IN_AW-1:0]      r_rd_ptr;
  logic [OUT_AW-1:0]     r_wr_ptr;
  logic [LANE_W-1:0]     r_lane;
  logic                  r_msb;
  logic [OUT_AW:0]       r_len;
  logic [OUT_AW:0]       r_words_done;
  logic                  r_done;

  logic                  w_out_we;
  logic                  w_last_word;
  logic [IN_WIDTH-1:0]   w_rd_data;
  logic [LANE_W-1:0]     w_lane_idx;

  assign w_rd_data   = r_in_ram[r_rd_ptr];
  assign w_lane_idx  = r_msb ? (c_LANE_LAST - r_lane) : r_lane;
  assign w_last_word = ((r_words_done + c_WD_ONE) == r_len);

  assign bus.out_data_rd = r_out_ram[bus.out_addr_rd];
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.words_done  = r_words_done;

  always_ff @(posedge clk) begin
    if (bus.in_we) begin
      r_in_ram[bus.in_addr_wr] <= bus.in_data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_out_we) begin
      r_out_ram[r_wr_ptr] <= r_pack;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort (and reset) suppress the output write so words_done always matches the RAM.
  always_comb begin
    w_next   = r_state;
    w_out_we = 1'b0;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next = S_READ;
        S_READ:  if (r_lane == c_LANE_LAST) w_next = S_WRITE;
        S_WRITE: begin
          w_out_we = !reset;
          w_next   = w_last_word ? S_IDLE : S_READ;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pack       <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_lane       <= '0;
      r_msb        <= 1'b0;
      r_len        <= '0;
      r_words_done <= '0;
      r_done       <= 1'b0;
    end else if (bus.abort) begin
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_msb        <= bus.msb_first;
            r_len        <= (bus.len_in == '0) ? c_OUT_DEPTH : {1'b0, bus.len_in};
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_lane       <= '0;
            r_words_done <= '0;
            r_done       <= 1'b0;
          end
        end
        S_READ: begin
          r_pack[int'(w_lane_idx) * IN_WIDTH +: IN_WIDTH] <= w_rd_data;
          r_rd_ptr <= r_rd_ptr + c_IN_ONE;
          r_lane   <= r_lane + c_LANE_ONE;
        end
        S_WRITE: begin
          r_wr_ptr     <= r_wr_ptr + c_OUT_ONE;
          r_words_done <= r_words_done + c_WD_ONE;
          r_lane       <= '0;
          if (w_last_word) begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ram_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_word_packer : randomized scoreboard bench for ram_word_packer      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_ram_word_packer;
  localparam int IN_WIDTH  = 8;
  localparam int RATIO     = 2;
  localparam int IN_DEPTH  = 32;
  localparam int OUT_DEPTH = IN_DEPTH / RATIO;
  localparam int OUT_AW    = $clog2(OUT_DEPTH);
  localparam int IN_AW     = $clog2(IN_DEPTH);
  localparam int OW        = IN_WIDTH * RATIO;

  typedef struct {
    int          addr;
    logic [OW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int cycles;
    bit done;
    int wd;
  } end_exp_t;

  logic clk;
  logic reset;
  ram_word_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .IN_DEPTH(IN_DEPTH)) bus ();

  ram_word_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .IN_DEPTH(IN_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [IN_WIDTH-1:0] in_mem  [IN_DEPTH];
  logic [OW-1:0]       out_mem [OUT_DEPTH];
  rd_exp_t  rd_q[$];
  end_exp_t end_q[$];
  int  checks = 0;
  int  failures = 0;
  int  edge_cnt = 0;
  int  start_edge = 0;
  int  last_wd = 0;
  bit  rd_strobe = 0;
  logic prev_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference packing: msb_first concatenates the first word on top, otherwise word k lands in lane k.
  function automatic logic [OW-1:0] model_word(input int j, input bit msb);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (msb) w = (w << IN_WIDTH) | OW'(in_mem[j*RATIO + k]);
      else     w = w | (OW'(in_mem[j*RATIO + k]) << (k * IN_WIDTH));
    end
    return w;
  endfunction

  always @(negedge clk) begin
    rd_exp_t  r;
    end_exp_t e;
    if (rd_strobe) begin
      if (rd_q.size() == 0) begin
        chk("rd_queue_underflow", 1, 0);
      end else begin
        r = rd_q.pop_front();
        chk($sformatf("out_word[%0d]", r.addr), 64'(bus.out_data_rd), 64'(r.data));
      end
    end
    if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
      if (end_q.size() == 0) begin
        chk("unexpected_run_end", 1, 0);
      end else begin
        e = end_q.pop_front();
        chk("run_cycles", 64'(edge_cnt - start_edge), 64'(e.cycles));
        chk("end_done", 64'(bus.done), 64'(e.done));
        chk("end_words_done", 64'(bus.words_done), 64'(e.wd));
      end
    end
    prev_busy = bus.busy;
  end

  task automatic fill(input bit rnd);
    logic [IN_WIDTH-1:0] d;
    for (int i = 0; i < IN_DEPTH; i++) begin
      d = rnd ? IN_WIDTH'($urandom) : IN_WIDTH'(i + 'h80 * (i % 2));
      bus.in_we = 1'b1; bus.in_addr_wr = IN_AW'(i); bus.in_data_wr = d;
      in_mem[i] = d;
      @(posedge clk); #1;
    end
    bus.in_we = 1'b0;
  endtask

  task automatic readback();
    for (int j = 0; j < OUT_DEPTH; j++) begin
      rd_q.push_back('{j, out_mem[j]});
      bus.out_addr_rd = OUT_AW'(j);
      rd_strobe = 1'b1;
      @(posedge clk); #1;
    end
    rd_strobe = 1'b0;
  endtask

  task automatic do_run(input int len_v, input bit msb, input int stop_at,
                        input bit by_reset, input bit extra_start);
    int n, words, lim;
    end_exp_t e;
    n = (len_v == 0) ? OUT_DEPTH : len_v;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len_in = OUT_AW'(len_v); bus.msb_first = msb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    start_edge = edge_cnt;
    chk("start_busy", 64'(bus.busy), 1);
    chk("start_done_clear", 64'(bus.done), 0);
    chk("start_wd_clear", 64'(bus.words_done), 0);
    if (stop_at > 0) begin
      words = (stop_at - 1) / (RATIO + 1);
      e.cycles = stop_at; e.done = 1'b0; e.wd = by_reset ? 0 : words;
    end else begin
      words = n;
      e.cycles = n * (RATIO + 1); e.done = 1'b1; e.wd = n;
    end
    for (int j = 0; j < words; j++) out_mem[j] = model_word(j, msb);
    end_q.push_back(e);
    if (stop_at > 0) begin
      repeat (stop_at - 1) @(posedge clk);
      #1;
      if (by_reset) reset = 1'b1; else bus.abort = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; bus.abort = 1'b0;
    end else if (extra_start) begin
      @(posedge clk); #1;
      bus.start = 1'b1; bus.len_in = OUT_AW'($urandom); bus.msb_first = ~msb;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    lim = n * (RATIO + 1) + 10;
    for (int c = 0; c < lim; c++) begin
      if (bus.busy !== 1'b1) break;
      @(posedge clk); #1;
    end
    if (bus.busy !== 1'b0) begin
      chk("run_timeout_busy", 64'(bus.busy), 0);
      void'(end_q.pop_front());
    end
    if (stop_at == 0) begin
      repeat (3) @(posedge clk);
      #1;
      chk("done_sticky", 64'(bus.done), 1);
    end
    last_wd = e.wd;
  endtask

  initial begin
    bus.in_we = 1'b0; bus.in_addr_wr = '0; bus.in_data_wr = '0; bus.out_addr_rd = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.msb_first = 1'b0; bus.len_in = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_done", 64'(bus.done), 0);
    chk("reset_words_done", 64'(bus.words_done), 0);

    fill(1'b0);
    do_run(0, 1'b1, 0, 1'b0, 1'b0);
    readback();
    do_run(0, 1'b0, 0, 1'b0, 1'b0);
    readback();
    fill(1'b1);
    do_run(3, 1'b1, 0, 1'b0, 1'b0);
    readback();
    fill(1'b0);
    do_run(0, 1'b0, 5, 1'b0, 1'b0);
    readback();
    do_run(0, 1'b1, 0, 1'b0, 1'b1);
    readback();
    do_run(4, 1'b0, 0, 1'b0, 1'b0);
    readback();

    // start and abort together in IDLE: no run, done cleared, words_done holds
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.len_in = '0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", 64'(bus.busy), 0);
    chk("start_abort_done", 64'(bus.done), 0);
    chk("start_abort_wd", 64'(bus.words_done), 64'(last_wd));
    repeat (2) @(posedge clk);
    #1;
    chk("start_abort_idle", 64'(bus.busy), 0);

    for (int it = 0; it < 10; it++) begin
      int len_v, n, stop;
      if ($urandom_range(0, 1) == 1) fill(1'b1);
      len_v = $urandom_range(0, OUT_DEPTH - 1);
      n = (len_v == 0) ? OUT_DEPTH : len_v;
      stop = ($urandom_range(0, 2) == 0) ? $urandom_range(2, n * (RATIO + 1)) : 0;
      do_run(len_v, 1'($urandom_range(0, 1)), stop, 1'b0, 1'($urandom_range(0, 1)));
      readback();
    end

    fill(1'b1);
    do_run(0, 1'b1, 2 * (RATIO + 1) + 2, 1'b1, 1'b0);
    chk("midrun_reset_busy", 64'(bus.busy), 0);
    chk("midrun_reset_done", 64'(bus.done), 0);
    chk("midrun_reset_wd", 64'(bus.words_done), 0);
    readback();

    repeat (3) @(posedge clk);
    #1;
    chk("end_queue_empty", 64'(end_q.size()), 0);
    chk("rd_queue_empty", 64'(rd_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
